// File: rtl/bp_cache_flush_sequencer.sv
// bp_cache_flush_sequencer: walks every set/way of an L1 cache to
// write back dirty lines and invalidate tag/stat state (flush or clear).
package bp_cache_flush_pkg;
  typedef enum logic [2:0] {
    e_COH_I = 3'd0
    ,e_COH_S = 3'd1
    ,e_COH_E = 3'd2
    ,e_COH_F = 3'd3
    ,e_COH_M = 3'd4
    ,e_COH_O = 3'd5
  } bp_coh_states_e;

  typedef enum logic [1:0] {
    e_cache_stat_mem_set_clear = 2'd0
    ,e_cache_stat_mem_read = 2'd1
    ,e_cache_stat_mem_clear_dirty = 2'd2
  } bp_cache_stat_mem_opcode_e;

  typedef enum logic [2:0] {
    e_cache_tag_mem_set_clear = 3'd0
    ,e_cache_tag_mem_set_tag = 3'd1
    ,e_cache_tag_mem_invalidate = 3'd2
    ,e_cache_tag_mem_read = 3'd3
  } bp_cache_tag_mem_opcode_e;

  typedef enum logic [1:0] {
    e_cache_data_mem_write = 2'd0
    ,e_cache_data_mem_read = 2'd1
    ,e_cache_data_mem_uncached = 2'd2
  } bp_cache_data_mem_opcode_e;
endpackage

module bp_cache_flush_sequencer
  import bp_cache_flush_pkg::*;
#(
  parameter int paddr_width_p = 40
  ,parameter int ptag_width_p = 28
  ,parameter int sets_p = 64
  ,parameter int assoc_p = 8
  ,parameter int block_width_p = 512
  ,localparam int lg_sets_lp =
    (sets_p > 1) ? $clog2(sets_p) : 1
  ,localparam int lg_assoc_lp =
    (assoc_p > 1) ? $clog2(assoc_p) : 1
  ,localparam int coh_w_lp = $bits(bp_coh_states_e)
  ,localparam int stat_pkt_w_lp =
    $bits(bp_cache_stat_mem_opcode_e)
    + lg_sets_lp + lg_assoc_lp
  ,localparam int tag_pkt_w_lp =
    $bits(bp_cache_tag_mem_opcode_e)
    + lg_sets_lp + lg_assoc_lp
    + ptag_width_p + coh_w_lp
  ,localparam int data_pkt_w_lp =
    $bits(bp_cache_data_mem_opcode_e)
    + lg_sets_lp + lg_assoc_lp
  ,localparam int offset_w_lp =
    paddr_width_p - ptag_width_p - lg_sets_lp
)(
  input  logic clk_i
  ,input  logic reset_n_i
  ,input  logic flush_v_i
  ,input  logic flush_mode_i
  ,output logic ready_o
  ,output logic done_v_o
  ,output logic [15:0] wb_count_o
  ,output logic stat_mem_pkt_v_o
  ,output logic [stat_pkt_w_lp-1:0] stat_mem_pkt_o
  ,input  logic stat_mem_pkt_yumi_i
  ,input  logic [assoc_p-1:0] stat_mem_dirty_i
  ,output logic tag_mem_pkt_v_o
  ,output logic [tag_pkt_w_lp-1:0] tag_mem_pkt_o
  ,input  logic tag_mem_pkt_yumi_i
  ,input  logic [ptag_width_p-1:0] tag_mem_tag_i
  ,input  logic [coh_w_lp-1:0] tag_mem_state_i
  ,output logic data_mem_pkt_v_o
  ,output logic [data_pkt_w_lp-1:0] data_mem_pkt_o
  ,input  logic data_mem_pkt_yumi_i
  ,input  logic [block_width_p-1:0] data_mem_i
  ,output logic wb_v_o
  ,input  logic wb_ready_i
  ,output logic [paddr_width_p-1:0] wb_addr_o
  ,output logic [block_width_p-1:0] wb_data_o
);

  typedef struct packed {
    bp_cache_stat_mem_opcode_e opcode;
    logic [lg_sets_lp-1:0] index;
    logic [lg_assoc_lp-1:0] way_id;
  } stat_pkt_s;

  typedef struct packed {
    bp_cache_tag_mem_opcode_e opcode;
    logic [lg_sets_lp-1:0] index;
    logic [lg_assoc_lp-1:0] way_id;
    logic [ptag_width_p-1:0] tag;
    logic [coh_w_lp-1:0] state;
  } tag_pkt_s;

  typedef struct packed {
    bp_cache_data_mem_opcode_e opcode;
    logic [lg_sets_lp-1:0] index;
    logic [lg_assoc_lp-1:0] way_id;
  } data_pkt_s;

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] STAT_RD  = 4'd1;
  localparam logic [3:0] STAT_CAP = 4'd2;
  localparam logic [3:0] TAG_RD   = 4'd3;
  localparam logic [3:0] TAG_CAP  = 4'd4;
  localparam logic [3:0] DATA_RD  = 4'd5;
  localparam logic [3:0] DATA_CAP = 4'd6;
  localparam logic [3:0] WB       = 4'd7;
  localparam logic [3:0] CLR_TAG  = 4'd8;
  localparam logic [3:0] CLR_STAT = 4'd9;
  localparam logic [3:0] DONE     = 4'd10;

  logic [3:0] state_r, state_n;
  logic [lg_sets_lp-1:0] index_r;
  logic [lg_assoc_lp-1:0] way_r;
  logic mode_r;
  logic [15:0] wb_count_r;
  logic [assoc_p-1:0] dirty_r;
  logic [ptag_width_p-1:0] tag_r;
  logic [block_width_p-1:0] data_r;

  logic accept, last_way, last_index;
  logic need_wb, wb_hs, way_adv, index_adv;
  stat_pkt_s stat_pkt;
  tag_pkt_s tag_pkt;
  data_pkt_s data_pkt;

  assign accept = (state_r == IDLE) & flush_v_i;
  assign last_way =
    (way_r == lg_assoc_lp'(assoc_p - 1));
  assign last_index =
    (index_r == lg_sets_lp'(sets_p - 1));
  assign need_wb = dirty_r[way_r]
    & (tag_mem_state_i != e_COH_I);
  assign wb_hs = (state_r == WB) & wb_ready_i;
  assign way_adv = wb_hs
    | ((state_r == TAG_CAP) & ~need_wb);
  assign index_adv = (state_r == CLR_STAT)
    & stat_mem_pkt_yumi_i & ~last_index;

  // next-state walk over sets and ways
  always_comb begin
    state_n = state_r;
    unique case (state_r)
      IDLE:
        if (flush_v_i)
          state_n = flush_mode_i ? CLR_TAG : STAT_RD;
      STAT_RD:
        if (stat_mem_pkt_yumi_i) state_n = STAT_CAP;
      STAT_CAP: state_n = TAG_RD;
      TAG_RD:
        if (tag_mem_pkt_yumi_i) state_n = TAG_CAP;
      TAG_CAP:
        if (need_wb) state_n = DATA_RD;
        else state_n = last_way ? CLR_TAG : TAG_RD;
      DATA_RD:
        if (data_mem_pkt_yumi_i) state_n = DATA_CAP;
      DATA_CAP: state_n = WB;
      WB:
        if (wb_ready_i)
          state_n = last_way ? CLR_TAG : TAG_RD;
      CLR_TAG:
        if (tag_mem_pkt_yumi_i) state_n = CLR_STAT;
      CLR_STAT:
        if (stat_mem_pkt_yumi_i) begin
          if (last_index) state_n = DONE;
          else state_n = mode_r ? CLR_TAG : STAT_RD;
        end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // control state, walk counters and writeback count
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      index_r <= '0;
      way_r <= '0;
      mode_r <= 1'b0;
      wb_count_r <= '0;
    end else begin
      state_r <= state_n;
      if (accept) begin
        index_r <= '0;
        way_r <= '0;
        mode_r <= flush_mode_i;
        wb_count_r <= '0;
      end
      if (way_adv && !last_way)
        way_r <= way_r + lg_assoc_lp'(1);
      if (index_adv) begin
        index_r <= index_r + lg_sets_lp'(1);
        way_r <= '0;
      end
      if (wb_hs && (wb_count_r != 16'hFFFF))
        wb_count_r <= wb_count_r + 16'd1;
    end
  end

  // read-data capture, one cycle after each read yumi
  always_ff @(posedge clk_i) begin
    if (state_r == STAT_CAP) dirty_r <= stat_mem_dirty_i;
    if (state_r == TAG_CAP) tag_r <= tag_mem_tag_i;
    if (state_r == DATA_CAP) data_r <= data_mem_i;
  end

  // packet fields derive only from held state, so stay stable
  always_comb begin
    stat_pkt.opcode = (state_r == CLR_STAT)
      ? e_cache_stat_mem_set_clear
      : e_cache_stat_mem_read;
    stat_pkt.index = index_r;
    stat_pkt.way_id = way_r;
    tag_pkt.opcode = (state_r == CLR_TAG)
      ? e_cache_tag_mem_set_clear
      : e_cache_tag_mem_read;
    tag_pkt.index = index_r;
    tag_pkt.way_id = way_r;
    tag_pkt.tag = '0;
    tag_pkt.state = e_COH_I;
    data_pkt.opcode = e_cache_data_mem_read;
    data_pkt.index = index_r;
    data_pkt.way_id = way_r;
  end

  assign ready_o = (state_r == IDLE);
  assign done_v_o = (state_r == DONE);
  assign wb_count_o = wb_count_r;
  assign stat_mem_pkt_v_o =
    (state_r == STAT_RD) | (state_r == CLR_STAT);
  assign tag_mem_pkt_v_o =
    (state_r == TAG_RD) | (state_r == CLR_TAG);
  assign data_mem_pkt_v_o = (state_r == DATA_RD);
  assign stat_mem_pkt_o = stat_pkt;
  assign tag_mem_pkt_o = tag_pkt;
  assign data_mem_pkt_o = data_pkt;
  assign wb_v_o = (state_r == WB);
  assign wb_addr_o =
    {tag_r, index_r, {offset_w_lp{1'b0}}};
  assign wb_data_o = data_r;

endmodule
